// File: rtl/la_rle_capture.sv
// Logic-analyser capture block: run-length encodes masked user signals after a
// configurable trigger and streams {run_count, sample} beats out over AXI-Stream.
module la_rle_capture #(
  parameter int pCH         = 24,
  parameter int pRC_W       = 8,
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16
) (
  input  logic                   axi_clk,
  input  logic                   la_reset_n,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  input  logic [pCH-1:0]         up_la_data,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   la_hpri_req
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] THRESH_H_RST = 8'(pDEPTH / 2);
  localparam logic [pRC_W-1:0] RC_ONE = pRC_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;

  state_e state_q, state_d;
  logic en_q;
  logic [1:0] trig_mode_q;
  logic [pCH-1:0] ch_en_q, trig_mask_q, trig_val_q;
  logic [7:0] pkt_len_q, thresh_h_q, thresh_l_q;
  logic [15:0] cap_len_q;
  logic ovf_q;

  logic [pCH-1:0] s, prev_q, prev_d, r_data_q, r_data_d;
  logic [pRC_W-1:0] rc_q, rc_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic gen_valid, gen_last, trig;

  logic [pDATA_WIDTH:0] mem_q [pDEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0] count16;
  logic push, pop, drop, ovf_clr;
  logic [pDATA_WIDTH:0] head;
  logic [7:0] bcnt_q, beat_max;
  logic unused_wdata;

  assign s = up_la_data & ch_en_q;
  assign unused_wdata = ^cfg_wdata;
  assign ovf_clr = cfg_we && (cfg_addr == 3'd0) && cfg_wdata[3];

  always_ff @(posedge axi_clk or negedge la_reset_n) begin
    if (!la_reset_n) begin
      en_q        <= 1'b0;
      trig_mode_q <= 2'd0;
      ch_en_q     <= '0;
      trig_mask_q <= '0;
      trig_val_q  <= '0;
      pkt_len_q   <= 8'd8;
      cap_len_q   <= 16'd0;
      thresh_h_q  <= THRESH_H_RST;
      thresh_l_q  <= 8'd2;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0: begin
          en_q        <= cfg_wdata[0];
          trig_mode_q <= cfg_wdata[2:1];
        end
        3'd1: ch_en_q     <= cfg_wdata[pCH-1:0];
        3'd2: trig_mask_q <= cfg_wdata[pCH-1:0];
        3'd3: trig_val_q  <= cfg_wdata[pCH-1:0];
        3'd4: pkt_len_q   <= cfg_wdata[7:0];
        3'd5: cap_len_q   <= cfg_wdata[15:0];
        3'd6: begin
          thresh_h_q <= cfg_wdata[15:8];
          thresh_l_q <= cfg_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0: cfg_rdata[2:0] = {trig_mode_q, en_q};
      3'd1: cfg_rdata[pCH-1:0] = ch_en_q;
      3'd2: cfg_rdata[pCH-1:0] = trig_mask_q;
      3'd3: cfg_rdata[pCH-1:0] = trig_val_q;
      3'd4: cfg_rdata[7:0] = pkt_len_q;
      3'd5: cfg_rdata[15:0] = cap_len_q;
      3'd6: cfg_rdata[15:0] = {thresh_h_q, thresh_l_q};
      default: cfg_rdata[15:0] = {count16[7:0], 5'd0, state_q, ovf_q};
    endcase
  end

  always_comb begin
    case (trig_mode_q)
      2'd0:    trig = 1'b1;
      2'd1:    trig = ((s & trig_mask_q) == (trig_val_q & trig_mask_q));
      2'd2:    trig = (((s ^ prev_q) & trig_mask_q) != '0);
      default: trig = 1'b0;
    endcase
  end

  always_ff @(posedge axi_clk or negedge la_reset_n) begin
    if (!la_reset_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      r_data_q  <= '0;
      rc_q      <= RC_ONE;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      r_data_q  <= r_data_d;
      rc_q      <= rc_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    r_data_d  = r_data_q;
    rc_d      = rc_q;
    pkt_cnt_d = pkt_cnt_q;
    gen_valid = 1'b0;
    gen_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = ARMED;
          prev_d  = s;
        end
      end
      ARMED: begin
        if (!en_q) begin
          state_d = IDLE;
        end else begin
          prev_d = s;
          if (trig) begin
            state_d   = CAPTURE;
            r_data_d  = s;
            rc_d      = RC_ONE;
            pkt_cnt_d = 16'd0;
          end
        end
      end
      CAPTURE: begin
        if (!en_q) begin
          gen_valid = 1'b1;
          gen_last  = 1'b1;
          state_d   = IDLE;
          rc_d      = RC_ONE;
        end else begin
          if (s != r_data_q) begin
            gen_valid = 1'b1;
            r_data_d  = s;
            rc_d      = RC_ONE;
          end else if (rc_q == '1) begin
            gen_valid = 1'b1;
            rc_d      = RC_ONE;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
          // Packets dropped on overflow still count toward the capture length
          if (gen_valid) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if ((cap_len_q != 16'd0) && (pkt_cnt_d == cap_len_q)) begin
              gen_last = 1'b1;
              state_d  = DONE;
            end
          end
        end
      end
      default: begin
        if (!en_q) state_d = IDLE;
      end
    endcase
  end

  assign pop  = m_tvalid && m_tready;
  assign push = gen_valid && ((count_q < CW'(pDEPTH)) || pop);
  assign drop = gen_valid && !push;
  assign count16 = 16'(count_q);

  always_ff @(posedge axi_clk) begin
    if (push) mem_q[wr_ptr_q] <= {gen_last, rc_q, r_data_q};
  end

  always_ff @(posedge axi_clk or negedge la_reset_n) begin
    if (!la_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      bcnt_q      <= 8'd0;
      la_hpri_req <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (pop) bcnt_q <= m_tlast ? 8'd0 : bcnt_q + 8'd1;
      if (count16 >= 16'(thresh_h_q))     la_hpri_req <= 1'b1;
      else if (count16 < 16'(thresh_l_q)) la_hpri_req <= 1'b0;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign beat_max = (pkt_len_q == 8'd0) ? 8'd0 : pkt_len_q - 8'd1;
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = m_tvalid ? head[pDATA_WIDTH-1:0] : '0;
  assign m_tlast  = m_tvalid && (head[pDATA_WIDTH] || (bcnt_q == beat_max));

endmodule

// File: tb/tb_la_rle_capture.sv
// Directed bench for la_rle_capture: every task applies hand-timed stimulus and
// compares outputs at the falling edge against hand-computed values.
module tb_la_rle_capture;

  logic        axi_clk = 1'b0;
  logic        la_reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd7;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic [23:0] up_la_data = 24'd0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic        la_hpri_req;

  int vectors = 0;
  int miscompares = 0;

  la_rle_capture dut (
    .axi_clk(axi_clk), .la_reset_n(la_reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .up_la_data(up_la_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .la_hpri_req(la_hpri_req)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Called at a falling edge; returns one falling edge after the write lands
  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    @(negedge axi_clk);
    cfg_we = 1'b0; cfg_addr = 3'd7;
  endtask

  task automatic do_reset();
    la_reset_n = 1'b0; m_tready = 1'b0; cfg_we = 1'b0; up_la_data = 24'd0; cfg_addr = 3'd7;
    repeat (2) @(negedge axi_clk);
    la_reset_n = 1'b1;
    @(negedge axi_clk);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [8];
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h0802, 32'h0};
    do_reset();
    vectors++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || la_hpri_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got valid=%b last=%b hpri=%b, want 0 0 0", m_tvalid, m_tlast, la_hpri_req);
    end
    for (int a = 0; a < 8; a++) begin
      cfg_addr = 3'(a); #1;
      vectors++;
      if (cfg_rdata !== exp_rst[a]) begin
        miscompares++;
        $display("[TB] FAIL reset_reg%0d: got %h want %h", a, cfg_rdata, exp_rst[a]);
      end
    end
    cfg_write(3'd7, 32'hFFFF_FFFF);
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL status_write_ignored: got %h want 0", cfg_rdata);
    end
  endtask

  task automatic test_mode0_run();
    do_reset();
    up_la_data = 24'h000001;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd0, 32'h1);
    repeat (6) @(negedge axi_clk);
    up_la_data = 24'h000002;
    @(negedge axi_clk);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0500_0001 || m_tlast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mode0_first_beat: got v=%b d=%h l=%b want 1 05000001 0", m_tvalid, m_tdata, m_tlast);
    end
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0104) begin
      miscompares++;
      $display("[TB] FAIL mode0_status: got %h want 00000104", cfg_rdata);
    end
  endtask

  task automatic test_long_run();
    do_reset();
    up_la_data = 24'hABCDEF;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd0, 32'h1);
    repeat (256) @(negedge axi_clk);
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL long_no_early_beat: got valid=%b want 0", m_tvalid);
    end
    @(negedge axi_clk);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hFFAB_CDEF) begin
      miscompares++;
      $display("[TB] FAIL long_saturated_beat: got v=%b d=%h want 1 ffabcdef", m_tvalid, m_tdata);
    end
    repeat (2) @(negedge axi_clk);
    up_la_data = 24'h000111;
    @(negedge axi_clk);
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0204) begin
      miscompares++;
      $display("[TB] FAIL long_status: got %h want 00000204", cfg_rdata);
    end
    m_tready = 1'b1;
    @(negedge axi_clk);
    m_tready = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h03AB_CDEF) begin
      miscompares++;
      $display("[TB] FAIL long_restart_beat: got v=%b d=%h want 1 03abcdef", m_tvalid, m_tdata);
    end
  endtask

  task automatic test_edge_trigger();
    do_reset();
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd2, 32'h1);
    cfg_write(3'd0, 32'h5);
    repeat (3) @(negedge axi_clk);
    up_la_data = 24'h000010;
    @(negedge axi_clk);
    #1;
    vectors++;
    if (cfg_rdata[2:1] !== 2'd1 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL edge_masked_change: got state=%0d v=%b want 1 0", cfg_rdata[2:1], m_tvalid);
    end
    repeat (4) @(negedge axi_clk);
    up_la_data = 24'h000011;
    @(negedge axi_clk);
    #1;
    vectors++;
    if (cfg_rdata[2:1] !== 2'd2 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL edge_triggered: got state=%0d v=%b want 2 0", cfg_rdata[2:1], m_tvalid);
    end
    up_la_data = 24'h000000;
    @(negedge axi_clk);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0100_0011) begin
      miscompares++;
      $display("[TB] FAIL edge_first_beat: got v=%b d=%h want 1 01000011", m_tvalid, m_tdata);
    end
  endtask

  task automatic test_cap_len();
    logic [31:0] exp_d [3];
    exp_d = '{32'h0100_0005, 32'h0100_000A, 32'h0100_0005};
    do_reset();
    up_la_data = 24'h5;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd5, 32'd3);
    cfg_write(3'd0, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      up_la_data = (i % 2 == 1) ? 24'hA : 24'h5;
      @(negedge axi_clk);
    end
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0306) begin
      miscompares++;
      $display("[TB] FAIL caplen_status: got %h want 00000306", cfg_rdata);
    end
    m_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_d[b] || m_tlast !== (b == 2)) begin
        miscompares++;
        $display("[TB] FAIL caplen_beat%0d: got v=%b d=%h l=%b want 1 %h %b", b + 1, m_tvalid, m_tdata, m_tlast, exp_d[b], b == 2);
      end
      @(negedge axi_clk);
    end
    m_tready = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL caplen_no_extra: got valid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    up_la_data = 24'h5;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd0, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      up_la_data = (i % 2 == 1) ? 24'hA : 24'h5;
      @(negedge axi_clk);
    end
    #1;
    vectors++;
    if (cfg_rdata !== 32'h1005 || la_hpri_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_full: got status=%h hpri=%b want 00001005 1", cfg_rdata, la_hpri_req);
    end
    vectors++;
    if (m_tdata !== 32'h0100_0005) begin
      miscompares++;
      $display("[TB] FAIL ovf_head: got %h want 01000005", m_tdata);
    end
    cfg_write(3'd0, 32'h9);
    #1;
    vectors++;
    if (cfg_rdata !== 32'h1004) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear: got %h want 00001004", cfg_rdata);
    end
    m_tready = 1'b1;
    repeat (15) @(negedge axi_clk);
    m_tready = 1'b0;
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0104 || la_hpri_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hpri_hold: got status=%h hpri=%b want 00000104 1", cfg_rdata, la_hpri_req);
    end
    @(negedge axi_clk);
    vectors++;
    if (la_hpri_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hpri_release: got %b want 0", la_hpri_req);
    end
  endtask

  task automatic test_pkt_len();
    do_reset();
    up_la_data = 24'h5;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd4, 32'd4);
    cfg_write(3'd0, 32'h1);
    for (int i = 1; i <= 12; i++) begin
      up_la_data = (i % 2 == 1) ? 24'hA : 24'h5;
      @(negedge axi_clk);
    end
    m_tready = 1'b1;
    for (int b = 1; b <= 10; b++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tlast !== (b == 4 || b == 8)) begin
        miscompares++;
        $display("[TB] FAIL pktlen_beat%0d: got v=%b l=%b want 1 %b", b, m_tvalid, m_tlast, b == 4 || b == 8);
      end
      @(negedge axi_clk);
    end
    m_tready = 1'b0;
    cfg_write(3'd0, 32'h0);
    @(negedge axi_clk);
    #1;
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0C00_0005 || m_tlast !== 1'b1 || cfg_rdata[2:1] !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_beat: got v=%b d=%h l=%b st=%0d want 1 0c000005 1 0", m_tvalid, m_tdata, m_tlast, cfg_rdata[2:1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    up_la_data = 24'h5;
    cfg_write(3'd1, 32'h00FF_FFFF);
    cfg_write(3'd0, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      up_la_data = (i % 2 == 1) ? 24'hA : 24'h5;
      @(negedge axi_clk);
    end
    #1;
    vectors++;
    if (cfg_rdata !== 32'h0404) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre_status: got %h want 00000404", cfg_rdata);
    end
    la_reset_n = 1'b0;
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || la_hpri_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got v=%b l=%b hpri=%b want 0 0 0", m_tvalid, m_tlast, la_hpri_req);
    end
    @(negedge axi_clk);
    la_reset_n = 1'b1;
    repeat (3) @(negedge axi_clk);
    #1;
    vectors++;
    if (m_tvalid !== 1'b0 || cfg_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_after: got v=%b status=%h want 0 00000000", m_tvalid, cfg_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_run();
    test_long_run();
    test_edge_trigger();
    test_cap_len();
    test_overflow();
    test_pkt_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
